// File: rtl/bus_sram_responder.sv
// Single-port word SRAM responder for a simple rd/wr bus: address decode, optional
// wait states, one-cycle ack with fault flag, byte-enable writes.
module bus_sram_responder #(
    parameter logic [31:0] BaseAddress = 32'h0000_0000,
    parameter int          Depth       = 1024,
    parameter int          WaitStates  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        fault,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    localparam int          IdxW      = $clog2(Depth);
    localparam logic [32:0] SpanBytes = 33'(Depth) << 2;
    localparam logic [3:0]  CntLoad   = (WaitStates > 0) ? 4'(WaitStates - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [3:0]        cnt;
    logic [IdxW-1:0]   idx_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic              op_rd_q;
    logic              op_wr_q;
    logic              fault_q;
    logic [31:0]       offset;
    logic              hit;
    logic              accept;
    logic              mem_we;
    logic [31:0]       mem [Depth];

    // Handshake: the initiator holds rd/wr (and addr/wdata/be) until it sees ack;
    // the request is captured once in IDLE and later bus changes are ignored.
    assign offset = addr - BaseAddress;
    assign hit    = (addr >= BaseAddress) && ({1'b0, offset} < SpanBytes);
    assign accept = (state == IDLE) && (rd || wr) && hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= 4'd0;
            op_rd_q <= 1'b0;
            op_wr_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                idx_q   <= offset[IdxW+1:2];
                wdata_q <= wdata;
                be_q    <= be;
                op_rd_q <= rd;
                op_wr_q <= wr;
                fault_q <= (rd && wr) || (wr && (be == 4'b0000));
                cnt     <= CntLoad;
            end else if ((state == WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = (WaitStates > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx = RESP;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state == WAIT) || (state == RESP);
        ack   = (state == RESP);
        fault = (state == RESP) && fault_q;
        rdata = 32'd0;
        if ((state == RESP) && op_rd_q && !fault_q) begin
            rdata = mem[idx_q];
        end
    end

    assign dbg_state = state;

    // Writes commit on the edge that ends RESP; a reset before then leaves memory untouched.
    assign mem_we = (state == RESP) && op_wr_q && !fault_q && !rst;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_sram_responder.sv
// Bench for bus_sram_responder: two instances (0 and 1 wait states), a transaction-level
// model with a per-cycle compare process, directed literal checks and random traffic.
module tb_bus_sram_responder;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE0 = 32'h0000_8000;
    localparam logic [31:0] BASE1 = 32'h0000_1000;
    localparam int          WS0   = 0;
    localparam int          WS1   = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst_v;
    logic [1:0]  rd_v;
    logic [1:0]  wr_v;
    logic [1:0]  ack_v;
    logic [1:0]  fault_v;
    logic [1:0]  busy_v;
    logic [31:0] addr_v  [2];
    logic [31:0] wdata_v [2];
    logic [31:0] rdata_v [2];
    logic [3:0]  be_v    [2];
    logic [1:0]  st_v    [2];

    bus_sram_responder #(.BaseAddress(BASE0), .Depth(DEPTH), .WaitStates(WS0)) dut0 (
        .clk(clk), .rst(rst_v[0]), .addr(addr_v[0]), .wdata(wdata_v[0]), .be(be_v[0]),
        .rd(rd_v[0]), .wr(wr_v[0]), .rdata(rdata_v[0]), .ack(ack_v[0]), .fault(fault_v[0]),
        .busy(busy_v[0]), .dbg_state(st_v[0])
    );

    bus_sram_responder #(.BaseAddress(BASE1), .Depth(DEPTH), .WaitStates(WS1)) dut1 (
        .clk(clk), .rst(rst_v[1]), .addr(addr_v[1]), .wdata(wdata_v[1]), .be(be_v[1]),
        .rd(rd_v[1]), .wr(wr_v[1]), .rdata(rdata_v[1]), .ack(ack_v[1]), .fault(fault_v[1]),
        .busy(busy_v[1]), .dbg_state(st_v[1])
    );

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: word memory plus the one transaction in flight per instance.
    logic [31:0] mdl_mem [2][DEPTH];
    bit          act   [2];
    int          acc   [2];
    bit          op_rd [2];
    bit          op_wr [2];
    bit          op_f  [2];
    int          op_idx[2];
    logic [31:0] op_wd [2];
    logic [3:0]  op_be [2];

    bit          got_ack;
    bit          got_busy;
    bit          got_fault;
    int          lat;
    logic [31:0] got_rdata;

    function automatic int ws(input int u);
        return (u == 0) ? WS0 : WS1;
    endfunction

    function automatic logic [31:0] base(input int u);
        return (u == 0) ? BASE0 : BASE1;
    endfunction

    function automatic bit is_hit(input int u, input logic [31:0] a);
        longint unsigned la;
        longint unsigned lb;
        la = longint'(a);
        lb = longint'(base(u));
        return (la >= lb) && (la < lb + 4 * DEPTH);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin : compare
        logic        e_ack;
        logic        e_busy;
        logic        e_fault;
        logic [31:0] e_rd;
        int          d;
        for (int u = 0; u < 2; u++) begin
            e_ack   = 1'b0;
            e_busy  = 1'b0;
            e_fault = 1'b0;
            e_rd    = 32'd0;
            if (!rst_v[u] && act[u]) begin
                d      = cyc - acc[u];
                e_busy = (d >= 0) && (d <= ws(u));
                if (d == ws(u)) begin
                    e_ack   = 1'b1;
                    e_fault = op_f[u];
                    if (!op_f[u] && op_rd[u]) e_rd = mdl_mem[u][op_idx[u]];
                end
            end
            chk($sformatf("u%0d ack", u),   32'(ack_v[u]),   32'(e_ack));
            chk($sformatf("u%0d busy", u),  32'(busy_v[u]),  32'(e_busy));
            chk($sformatf("u%0d fault", u), 32'(fault_v[u]), 32'(e_fault));
            chk($sformatf("u%0d rdata", u), rdata_v[u],      e_rd);
        end
    end

    // Drive one request at posedge+1 and hold it until the edge that ends RESP (or
    // for miss_cyc cycles on a miss). Inputs are left asserted on return.
    task automatic issue(input int u, input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] b, input int miss_cyc);
        bit h;
        int n;
        h = is_hit(u, a) && (r || w);
        rd_v[u] = r; wr_v[u] = w; addr_v[u] = a; wdata_v[u] = wd; be_v[u] = b;
        got_ack = 0; got_busy = 0; got_fault = 0; lat = -1; got_rdata = 32'd0;
        if (h) begin
            act[u]    = 1'b1;
            acc[u]    = cyc + 1;
            op_rd[u]  = r;
            op_wr[u]  = w;
            op_f[u]   = (r && w) || (w && (b == 4'b0000));
            op_idx[u] = int'((a - base(u)) >> 2);
            op_wd[u]  = wd;
            op_be[u]  = b;
            n = ws(u) + 2;
        end else begin
            n = miss_cyc;
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (busy_v[u] === 1'b1) got_busy = 1;
            if (ack_v[u] === 1'b1 && !got_ack) begin
                got_ack = 1; lat = i; got_rdata = rdata_v[u]; got_fault = fault_v[u];
            end
            @(posedge clk);
        end
        #1;
        if (h) begin
            if (op_wr[u] && !op_f[u]) begin
                for (int k = 0; k < 4; k++)
                    if (op_be[u][k]) mdl_mem[u][op_idx[u]][8*k +: 8] = op_wd[u][8*k +: 8];
            end
            act[u] = 1'b0;
        end
    endtask

    task automatic idle(input int u, input int n);
        rd_v[u] = 1'b0;
        wr_v[u] = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          u;
        int          last_u;
        int          cat;
        int          o;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  b;
        bit          r;
        bit          w;

        rst_v = 2'b11; rd_v = 2'b00; wr_v = 2'b00;
        for (int k = 0; k < 2; k++) begin
            addr_v[k] = 32'd0; wdata_v[k] = 32'd0; be_v[k] = 4'd0; act[k] = 1'b0; acc[k] = 0;
        end
        #2;
        chk("reset ack",   32'(ack_v),   32'd0);
        chk("reset busy",  32'(busy_v),  32'd0);
        chk("reset fault", 32'(fault_v), 32'd0);
        chk("reset rdata0", rdata_v[0],  32'd0);
        chk("reset rdata1", rdata_v[1],  32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_v = 2'b00;

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < DEPTH; i++) issue(k, 0, 1, base(k) + 32'(4 * i), $urandom, 4'hF, 0);
            idle(k, 1);
        end

        // Write then read through the one-wait-state instance.
        issue(1, 0, 1, 32'h1004, 32'hDEADBEEF, 4'hF, 0); idle(1, 1);
        issue(1, 1, 0, 32'h1004, 32'h0, 4'h0, 0);
        chk("rd latency ws1", 32'(lat), 32'd2);
        chk("rd data beef", got_rdata, 32'hDEADBEEF);
        chk("rd fault beef", 32'(got_fault), 32'd0);
        idle(1, 1);

        issue(1, 0, 1, 32'h1004, 32'h0000_00AA, 4'b0001, 0); idle(1, 1);
        issue(1, 1, 0, 32'h1004, 32'h0, 4'h0, 0);
        chk("byte merge", got_rdata, 32'hDEADBEAA);
        idle(1, 1);

        // Decode boundaries.
        issue(1, 1, 0, 32'h0000_0FFC, 32'h0, 4'h0, 20);
        chk("below base ack", 32'(got_ack), 32'd0);
        chk("below base busy", 32'(got_busy), 32'd0);
        idle(1, 1);
        issue(1, 1, 0, BASE1 + 32'(4 * DEPTH), 32'h0, 4'h0, 20);
        chk("past end ack", 32'(got_ack), 32'd0);
        chk("past end busy", 32'(got_busy), 32'd0);
        idle(1, 1);
        issue(1, 1, 0, BASE1 + 32'(4 * (DEPTH - 1)), 32'h0, 4'h0, 0);
        chk("last word ack", 32'(got_ack), 32'd1);
        idle(1, 1);

        // Faulting requests leave memory alone.
        issue(1, 0, 1, 32'h1000, 32'h0BADF00D, 4'hF, 0); idle(1, 1);
        issue(1, 1, 1, 32'h1000, 32'hFFFF_FFFF, 4'hF, 0);
        chk("rdwr ack", 32'(got_ack), 32'd1);
        chk("rdwr fault", 32'(got_fault), 32'd1);
        chk("rdwr rdata", got_rdata, 32'd0);
        idle(1, 1);
        issue(1, 0, 1, 32'h1000, 32'h1111_1111, 4'h0, 0);
        chk("be0 fault", 32'(got_fault), 32'd1);
        chk("be0 rdata", got_rdata, 32'd0);
        idle(1, 1);
        issue(1, 1, 0, 32'h1000, 32'h0, 4'h0, 0);
        chk("after fault data", got_rdata, 32'h0BADF00D);
        idle(1, 1);

        // Reset during the wait cycle of a write.
        issue(1, 0, 1, 32'h1008, 32'hCAFEF00D, 4'hF, 0); idle(1, 1);
        rd_v[1] = 0; wr_v[1] = 1; addr_v[1] = 32'h1008; wdata_v[1] = 32'h1234_5678; be_v[1] = 4'hF;
        act[1] = 1; acc[1] = cyc + 1; op_rd[1] = 0; op_wr[1] = 1; op_f[1] = 0; op_idx[1] = 2;
        @(posedge clk);
        #1;
        chk("busy in wait", 32'(busy_v[1]), 32'd1);
        #1;
        rst_v[1] = 1'b1; act[1] = 1'b0; wr_v[1] = 1'b0;
        #1;
        chk("busy at reset", 32'(busy_v[1]), 32'd0);
        chk("ack at reset", 32'(ack_v[1]), 32'd0);
        @(posedge clk);
        #1;
        rst_v[1] = 1'b0;
        idle(1, 1);
        issue(1, 1, 0, 32'h1008, 32'h0, 4'h0, 0);
        chk("old value kept", got_rdata, 32'hCAFEF00D);
        idle(1, 1);

        // Zero wait states, write immediately followed by read.
        issue(0, 0, 1, BASE0 + 32'h10, 32'h55AA_1234, 4'hF, 0);
        chk("b2b wr latency", 32'(lat), 32'd1);
        issue(0, 1, 0, BASE0 + 32'h10, 32'h0, 4'h0, 0);
        chk("b2b rd latency", 32'(lat), 32'd1);
        chk("b2b rd data", got_rdata, 32'h55AA_1234);
        idle(0, 1);

        last_u = 0;
        for (int k = 0; k < 300; k++) begin
            u = $urandom_range(0, 1);
            if (u != last_u) begin
                rd_v[last_u] = 1'b0;
                wr_v[last_u] = 1'b0;
            end
            cat = $urandom_range(0, 11);
            if (cat <= 7)       a = base(u) + 32'(4 * $urandom_range(0, DEPTH - 1));
            else if (cat == 8)  a = base(u) - 32'd4;
            else if (cat == 9)  a = base(u) + 32'(4 * DEPTH);
            else if (cat == 10) a = base(u) + 32'(4 * (DEPTH - 1));
            else                a = $urandom;
            a  = a + 32'($urandom_range(0, 3));
            o  = $urandom_range(0, 9);
            r  = (o <= 3) || (o == 8);
            w  = (o >= 4);
            wd = $urandom;
            b  = (o == 9) ? 4'h0 : 4'($urandom_range(0, 15));
            issue(u, r, w, a, wd, b, $urandom_range(1, 4));
            if ($urandom_range(0, 1) == 1) idle(u, $urandom_range(1, 2));
            last_u = u;
        end
        idle(0, 0);
        idle(1, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
